// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-access-per-cycle sequencer sharing the unified memory between fetch and load/store
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (instruction region 0-255)
//   if_gnt/if_rvalid/if_rdata  fetch grant, response one cycle later
//   d_req/d_we/d_funct3/d_addr/d_wdata  load/store request (data region, offset by DATA_BASE)
//   d_gnt/d_rvalid/d_rdata     data grant, load response one cycle later
//   mem_*                      memory port; mem_rdata is valid the cycle after a read strobe
// Optional: define ARB_PERF_CNT_EN to add if_stall_cnt/d_stall_cnt stall counters.
module mem_port_arbiter #(
  parameter int MAX_D_BURST = 4,
  parameter int DATA_BASE   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [8:0]  mem_addr,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_wdata,
`ifdef ARB_PERF_CNT_EN
  output logic [31:0] if_stall_cnt,
  output logic [31:0] d_stall_cnt,
`endif
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {NONE, IF_RD, D_RD, D_WR} owner_e;
  owner_e     owner_q, owner_d;
  logic [3:0] streak_q, streak_d;
  logic       fetch_forced;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d, d_stall_q, d_stall_d;
  assign if_stall_cnt = if_stall_q;
  assign d_stall_cnt  = d_stall_q;
`endif
  always_comb begin
    fetch_forced = streak_q == 4'(MAX_D_BURST);
    // rst_n gates grants so no memory access can start while reset is held
    if_gnt     = rst_n && if_req && (!d_req || fetch_forced);
    d_gnt      = rst_n && d_req && !if_gnt;
    streak_d   = (!if_req || if_gnt) ? 4'd0 : (d_gnt && !fetch_forced) ? streak_q + 4'd1 : streak_q;
    owner_d    = if_gnt ? IF_RD : d_gnt ? (d_we ? D_WR : D_RD) : NONE;
    mem_en     = if_gnt || d_gnt;
    mem_we     = d_gnt && d_we;
    mem_addr   = if_gnt ? {1'b0, if_addr} : d_gnt ? {1'b0, d_addr} + 9'(DATA_BASE) : 9'd0;
    mem_funct3 = if_gnt ? 3'b010 : d_gnt ? d_funct3 : 3'd0;
    mem_wdata  = d_gnt ? d_wdata : 32'd0;
    if_rvalid  = owner_q == IF_RD;
    d_rvalid   = owner_q == D_RD;
    if_rdata   = if_rvalid ? mem_rdata : 32'd0;
    d_rdata    = d_rvalid ? mem_rdata : 32'd0;
`ifdef ARB_PERF_CNT_EN
    if_stall_d = if_stall_q + 32'(if_req && !if_gnt);
    d_stall_d  = d_stall_q + 32'(d_req && !d_gnt);
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= NONE;
      streak_q <= 4'd0;
`ifdef ARB_PERF_CNT_EN
      if_stall_q <= 32'd0;
      d_stall_q  <= 32'd0;
`endif
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
`ifdef ARB_PERF_CNT_EN
      if_stall_q <= if_stall_d;
      d_stall_q  <= d_stall_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  logic clk = 0, rst_n = 0;
  logic if_req = 0;
  logic [7:0] if_addr = 0;
  logic if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic d_req = 0, d_we = 0;
  logic [2:0] d_funct3 = 0;
  logic [7:0] d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic mem_en, mem_we;
  logic [8:0] mem_addr;
  logic [2:0] mem_funct3;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, d_stall_cnt;
`endif
  logic bd_we = 0;
  logic [8:0] bd_addr = 0;
  logic [31:0] bd_data = 0;
  logic [7:0] mem [512];
  logic [7:0] ref_mem [512];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_D_BURST(MAXB), .DATA_BASE(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
`ifdef ARB_PERF_CNT_EN
    .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd4: return {24'd0, w[7:0]};
      3'd5: return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [8:0] a);
    return {ref_mem[a + 9'd3], ref_mem[a + 9'd2], ref_mem[a + 9'd1], ref_mem[a]};
  endfunction

  // Memory array seen by the DUT: byte-sized stores at the posedge, read data one cycle later,
  // junk on mem_rdata in cycles without a read so rdata zeroing is exercised.
  always @(posedge clk) begin
    if (bd_we)
      for (int i = 0; i < 4; i++) mem[bd_addr + 9'(i)] <= bd_data[8*i +: 8];
    if (mem_en && mem_we)
      for (int i = 0; i < 4; i++)
        if (i < nbytes(mem_funct3)) mem[mem_addr + 9'(i)] <= mem_wdata[8*i +: 8];
    mem_rdata <= (mem_en && !mem_we) ?
      ext({mem[mem_addr + 9'd3], mem[mem_addr + 9'd2], mem[mem_addr + 9'd1], mem[mem_addr]}, mem_funct3) : $urandom;
  end

  task automatic poke(input logic [8:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[a + 9'(i)] = w[8*i +: 8];
    bd_addr = a; bd_data = w; bd_we = 1;
    @(posedge clk); #1;
    bd_we = 0;
  endtask

  task automatic test_reset;
    if_req = 1; d_req = 1; d_addr = 8'h08;
    #1;
    tests++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0)
      begin fails++; $display("FAIL reset_gnt: gnt/en/we=%b required 0000", {if_gnt, d_gnt, mem_en, mem_we}); end
    tests++;
    if ({if_rvalid, d_rvalid} !== 2'b0 || if_rdata !== 0 || d_rdata !== 0)
      begin fails++; $display("FAIL reset_resp: rvalid=%b if_rdata=%h d_rdata=%h required 0", {if_rvalid, d_rvalid}, if_rdata, d_rdata); end
    @(posedge clk); #1;
    rst_n = 1; if_req = 0; d_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch;
    poke(9'h004, 32'h00002083);
    if_req = 1; if_addr = 8'h04;
    #1;
    tests++;
    if (!(if_gnt === 1 && d_gnt === 0 && mem_en === 1 && mem_we === 0 && mem_addr === 9'h004 && mem_funct3 === 3'b010))
      begin fails++; $display("FAIL fetch_grant: gnt=%b%b en=%b we=%b addr=%h f3=%b required 10 1 0 004 010", if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_funct3); end
    @(posedge clk); #1;
    if_req = 0;
    tests++;
    if (if_rvalid !== 1 || if_rdata !== 32'h00002083 || d_rvalid !== 0)
      begin fails++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h d_rvalid=%b required 1 00002083 0", if_rvalid, if_rdata, d_rvalid); end
    @(posedge clk); #1;
    tests++;
    if (if_rvalid !== 0 || if_rdata !== 0)
      begin fails++; $display("FAIL fetch_idle: if_rvalid=%b if_rdata=%h required 0 0", if_rvalid, if_rdata); end
  endtask

  task automatic test_load;
    poke(9'h108, 32'd25);
    d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 8'h08;
    #1;
    tests++;
    if (!(d_gnt === 1 && if_gnt === 0 && mem_en === 1 && mem_we === 0 && mem_addr === 9'h108 && mem_funct3 === 3'b010))
      begin fails++; $display("FAIL load_grant: gnt=%b%b en=%b we=%b addr=%h f3=%b required 01 1 0 108 010", if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_funct3); end
    @(posedge clk); #1;
    d_req = 0;
    tests++;
    if (d_rvalid !== 1 || d_rdata !== 32'd25 || if_rvalid !== 0)
      begin fails++; $display("FAIL load_resp: d_rvalid=%b d_rdata=%0d if_rvalid=%b required 1 25 0", d_rvalid, d_rdata, if_rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    d_req = 1; d_we = 1; d_funct3 = 3'b010; d_addr = 8'h0C; d_wdata = 32'd34;
    #1;
    tests++;
    if (!(d_gnt === 1 && mem_we === 1 && mem_addr === 9'h10C && mem_wdata === 32'd34))
      begin fails++; $display("FAIL store_grant: d_gnt=%b we=%b addr=%h wdata=%0d required 1 1 10c 34", d_gnt, mem_we, mem_addr, mem_wdata); end
    for (int i = 0; i < 4; i++) ref_mem[9'h10C + 9'(i)] = d_wdata[8*i +: 8];
    @(posedge clk); #1;
    d_we = 0;
    #1;
    tests++;
    if (d_rvalid !== 0 || d_rdata !== 0 || d_gnt !== 1)
      begin fails++; $display("FAIL store_noresp: d_rvalid=%b d_rdata=%h d_gnt=%b required 0 0 1", d_rvalid, d_rdata, d_gnt); end
    @(posedge clk); #1;
    d_req = 0;
    tests++;
    if (d_rvalid !== 1 || d_rdata !== 32'd34)
      begin fails++; $display("FAIL store_then_load: d_rvalid=%b d_rdata=%0d required 1 34", d_rvalid, d_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    logic fw;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] is0, ds0;
    is0 = if_stall_cnt; ds0 = d_stall_cnt;
`endif
    if_req = 1; if_addr = 8'h10; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 8'h20;
    for (int c = 0; c < 10; c++) begin
      fw = (c % (MAXB + 1)) == MAXB;
      #1;
      tests++;
      if (if_gnt !== fw || d_gnt !== !fw)
        begin fails++; $display("FAIL burst_gnt[%0d]: if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, fw, !fw); end
      @(posedge clk); #1;
      tests++;
      if (if_rvalid !== fw || d_rvalid !== !fw || (fw ? if_rdata : d_rdata) !== (fw ? ref_word(9'h010) : ref_word(9'h120)))
        begin fails++; $display("FAIL burst_resp[%0d]: rvalid=%b%b if_rdata=%h d_rdata=%h", c, if_rvalid, d_rvalid, if_rdata, d_rdata); end
    end
`ifdef ARB_PERF_CNT_EN
    tests++;
    if (if_stall_cnt - is0 !== 32'd8 || d_stall_cnt - ds0 !== 32'd2)
      begin fails++; $display("FAIL perf_cnt: if_stall delta=%0d d_stall delta=%0d required 8 2", if_stall_cnt - is0, d_stall_cnt - ds0); end
`endif
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    if_req = 1; if_addr = 8'h00; d_req = 1; d_we = 0; d_funct3 = 3'b010; d_addr = 8'h08;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (d_gnt !== 1)
        begin fails++; $display("FAIL rstmid_pre[%0d]: d_gnt=%b required 1", c, d_gnt); end
      @(posedge clk); #1;
    end
    rst_n = 0;
    #1;
    tests++;
    if ({d_rvalid, if_rvalid, mem_en, mem_we, if_gnt, d_gnt} !== 6'b0 || d_rdata !== 0)
      begin fails++; $display("FAIL rstmid_assert: rv/en/we/gnt=%b d_rdata=%h required 000000 0", {d_rvalid, if_rvalid, mem_en, mem_we, if_gnt, d_gnt}, d_rdata); end
    @(posedge clk); #1;
    rst_n = 1; if_req = 0; d_req = 0;
    @(posedge clk); #1;
    tests++;
    if (d_rvalid !== 0 || if_rvalid !== 0)
      begin fails++; $display("FAIL rstmid_release: d_rvalid=%b if_rvalid=%b required 0 0", d_rvalid, if_rvalid); end
    if_req = 1; d_req = 1;
    for (int c = 0; c <= MAXB; c++) begin
      #1;
      tests++;
      if (if_gnt !== (c == MAXB) || d_gnt !== (c != MAXB))
        begin fails++; $display("FAIL rstmid_streak[%0d]: if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, c == MAXB, c != MAXB); end
      @(posedge clk); #1;
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
  endtask

  // Model: each requester holds its request until granted; data has priority, but once fetch
  // has waited through MAXB data grants in a row it is served. Responses come from a reference
  // image of memory one cycle after the grant.
  task automatic test_random;
    bit if_pend = 0, d_pend = 0, ig, dg;
    int waited = 0, rk = 0;
    logic [31:0] rd = 0;
    logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [15:0] exp_port;
    for (int c = 0; c < 400; c++) begin
      tests++;
      if (if_rvalid !== (rk == 1) || if_rdata !== (rk == 1 ? rd : 32'd0))
        begin fails++; $display("FAIL rand_if_resp[%0d]: if_rvalid=%b if_rdata=%h required %b %h", c, if_rvalid, if_rdata, rk == 1, rk == 1 ? rd : 32'd0); end
      tests++;
      if (d_rvalid !== (rk == 2) || d_rdata !== (rk == 2 ? rd : 32'd0))
        begin fails++; $display("FAIL rand_d_resp[%0d]: d_rvalid=%b d_rdata=%h required %b %h", c, d_rvalid, d_rdata, rk == 2, rk == 2 ? rd : 32'd0); end
      if (!if_pend && $urandom_range(0, 3) != 0) begin
        if_pend = 1; if_addr = 8'($urandom_range(0, 63) * 4);
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_we = 1'($urandom); d_funct3 = f3s[$urandom_range(0, 4)];
        d_addr = 8'($urandom_range(0, 252)); d_wdata = $urandom;
      end
      if_req = if_pend; d_req = d_pend;
      #1;
      ig = if_pend && (!d_pend || waited == MAXB);
      dg = d_pend && !ig;
      tests++;
      if (if_gnt !== ig || d_gnt !== dg)
        begin fails++; $display("FAIL rand_gnt[%0d]: if_gnt=%b d_gnt=%b required %b %b", c, if_gnt, d_gnt, ig, dg); end
      exp_port = ig ? {1'b1, 1'b0, 1'b0, if_addr, 3'b010} :
                 dg ? {1'b1, d_we, 9'(d_addr) + 9'd256, d_funct3} : 16'd0;
      tests++;
      if ({mem_en, mem_we, mem_addr, mem_funct3} !== exp_port || ((dg || !ig) && mem_wdata !== (dg ? d_wdata : 32'd0)))
        begin fails++; $display("FAIL rand_port[%0d]: en/we/addr/f3=%h wdata=%h required %h", c, {mem_en, mem_we, mem_addr, mem_funct3}, mem_wdata, exp_port); end
      rk = ig ? 1 : (dg && !d_we) ? 2 : 0;
      rd = ig ? ref_word({1'b0, if_addr}) : ext(ref_word(9'(d_addr) + 9'd256), d_funct3);
      if (dg && d_we)
        for (int i = 0; i < nbytes(d_funct3); i++) ref_mem[9'(d_addr) + 9'd256 + 9'(i)] = d_wdata[8*i +: 8];
      waited = (!if_pend || ig) ? 0 : waited + 1;
      if (ig) if_pend = 0;
      if (dg) d_pend = 0;
      @(posedge clk); #1;
    end
    if_req = 0; d_req = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int a = 0; a < 512; a += 4) poke(9'(a), $urandom);
    test_reset;
    test_fetch;
    test_load;
    test_store_load;
    test_burst;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the single unified instruction/data memory between the fetch stage and the MEM-stage load/store unit. Replaces the clock-phase split with a one-access-per-cycle sequencer: it grants one requester per cycle and drives the memory port. It returns read data one cycle later to whichever requester owned the read. Sits between IF/MEM pipeline stages and the byte-addressed memory array, where instructions occupy 0-255 and data occupies 256-511.

Parameters:
MAX_D_BURST, 4, max consecutive data grants while fetch is waiting before fetch is forced through (legal 1..15)
DATA_BASE, 256, physical offset added to data addresses

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request
if_addr  in  8  fetch byte address (instruction region)
if_gnt  out  1  fetch granted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  32  instruction word
d_req  in  1  data request
d_we  in  1  1=store, 0=load
d_funct3  in  3  access size/sign (lb/lh/lw/lbu/lhu, sb/sh/sw encodings)
d_addr  in  8  data byte offset
d_wdata  in  32  store data
d_gnt  out  1  data granted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  32  load result
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  9  physical byte address
mem_funct3  out  3  size code to memory
mem_wdata  out  32  write data
mem_rdata  in  32  memory read data, valid the cycle after a read strobe

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Grant is combinational in cycle t from the requests, the fairness counter and reset. At most one of if_gnt and d_gnt is high.
- Arbitration:
  - d_req alone: data wins.
  - if_req alone: fetch wins.
  - Both requesting: data wins unless streak == MAX_D_BURST, in which case fetch wins.
- streak counter (4 bits):
  - +1 on each cycle data wins while if_req=1, saturating at MAX_D_BURST.
  - Cleared on any fetch grant, or any cycle with if_req=0.
- Memory drive in the grant cycle:
  - Fetch: mem_en=1, mem_we=0, mem_addr={1'b0,if_addr}, mem_funct3=3'b010.
  - Data: mem_en=1, mem_we=d_we, mem_addr=if_addr-independent d_addr+DATA_BASE (9-bit, no wrap), mem_funct3=d_funct3, mem_wdata=d_wdata.
  - No grant: mem_en=0, mem_we=0, all other mem_* outputs 0.
- Owner state register, states NONE, IF_RD, D_RD, D_WR, is loaded at each posedge with the granted access type.
  - State IF_RD in cycle t+1 → if_rvalid=1 and if_rdata=mem_rdata.
  - State D_RD in cycle t+1 → d_rvalid=1 and d_rdata=mem_rdata.
  - State D_WR and state NONE → no rvalid.
- Each rdata output reads 0 whenever its rvalid is low.
- Latency: grant to rvalid is exactly 1 cycle. Back-to-back grants give one response per cycle.
- Stores complete at the grant-cycle posedge. A load granted in the next cycle observes the stored data.
- Requesters hold req/addr/data stable until their gnt is seen. The arbiter does not latch requests.
- Reset values: owner=NONE, streak=0, all rvalid=0, all rdata=0. While rst_n=0, gnts=0 and mem_en=mem_we=0.
- Reset mid-operation: an outstanding read response is discarded and no rvalid follows reset release.
- d_funct3 is passed unchecked; illegal codes are the memory's concern.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs if_stall_cnt[31:0] (cycles with if_req=1 and if_gnt=0) and d_stall_cnt[31:0] (cycles with d_req=1 and d_gnt=0).
  - Both counters clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; arbitration is identical.

Test Plan:
- Fetch only, if_addr=0x04 with mem[4..7]=lw x1,0(x0) encoding: if_gnt same cycle, mem_addr=0x004, if_rvalid next cycle with if_rdata=0x00002083.
- Load only, d_addr=0x08, d_funct3=010, mem[264..267]=25: mem_addr=0x108, d_rvalid next cycle with d_rdata=25; if_rvalid stays 0.
- Store then load: sw of 34 at d_addr=0x0C, then lw at 0x0C the next cycle → d_rdata=34.
- Continuous if_req and d_req, MAX_D_BURST=4: grant pattern D,D,D,D,F repeating; if_gnt never low for more than 4 consecutive cycles.
- rst_n asserted the cycle after a load grant: d_rvalid=0 and mem_en=0 immediately; no response after release; streak=0.
- With ARB_PERF_CNT_EN, 10 cycles of both requesting at MAX_D_BURST=4: if_stall_cnt=8, d_stall_cnt=2.
